// File: rtl/pi1_pkg.sv
// Shared pi1 bus definitions: op encodings, width helpers.
package pi1_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Word address width: byte offset bits are dropped.
    function automatic int unsigned addrbitsz(input int unsigned archbitsz);
        return archbitsz - clog2(archbitsz / 8);
    endfunction

endpackage

// File: rtl/pi1_arb_rrpick.sv
// Combinational round-robin picker: first requester after ref_idx, wrapping around.
module pi1_arb_rrpick
    import pi1_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2,
    localparam int unsigned IDXW = clog2(MASTERCOUNT)
) (
    input  logic [MASTERCOUNT-1:0] req,
    input  logic [IDXW-1:0]        ref_idx,
    output logic                   found,
    output logic [IDXW-1:0]        winner
);

    int unsigned idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        // Offset MASTERCOUNT wraps back to ref_idx itself, so it is considered last.
        for (int unsigned k = 1; k <= MASTERCOUNT; k++) begin
            idx = (32'(ref_idx) + k) % MASTERCOUNT;
            if (!found && req[idx[IDXW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/pi1_arb.sv
// Round-robin arbiter sharing one pi1 slave between MASTERCOUNT masters.
// Optional forced release after BURSTMAX accepts: define PI1ARB_BURSTLIMIT_EN.
module pi1_arb
    import pi1_pkg::*;
#(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARCHBITSZ   = 32,
    parameter int unsigned BURSTMAX    = 16,
    localparam int unsigned ADDRBITSZ  = addrbitsz(ARCHBITSZ),
    localparam int unsigned SELW       = ARCHBITSZ / 8,
    localparam int unsigned IDXW       = clog2(MASTERCOUNT)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i,
    input  logic [SELW*MASTERCOUNT-1:0]      m_pi1_sel_i,
    output logic [ARCHBITSZ-1:0]             m_pi1_data_o,
    output logic [MASTERCOUNT-1:0]           m_pi1_rdy_o,
    output logic [ADDRBITSZ-1:0]             m_pi1_mapsz_o,
    output logic [1:0]                       s_pi1_op_o,
    output logic [ADDRBITSZ-1:0]             s_pi1_addr_o,
    output logic [ARCHBITSZ-1:0]             s_pi1_data_o,
    output logic [SELW-1:0]                  s_pi1_sel_o,
    input  logic [ARCHBITSZ-1:0]             s_pi1_data_i,
    input  logic                             s_pi1_rdy_i,
    input  logic [ADDRBITSZ-1:0]             s_pi1_mapsz_i
);

    if (MASTERCOUNT < 2 || MASTERCOUNT > 8 || BURSTMAX < 1) begin : g_param_chk
        $fatal(1, "pi1_arb: MASTERCOUNT must be 2..8 and BURSTMAX at least 1");
    end

    logic                   gntvld_r;
    logic [IDXW-1:0]        gnt_r;
    logic [IDXW-1:0]        lastgnt_r;

    logic [MASTERCOUNT-1:0] req;
    logic [1:0]             own_op;
    logic [ADDRBITSZ-1:0]   own_addr;
    logic [ARCHBITSZ-1:0]   own_data;
    logic [SELW-1:0]        own_sel;
    logic                   force_rel;
    logic                   rel;
    logic                   fwd;
    logic                   arb_en;
    logic                   found;
    logic [IDXW-1:0]        winner;
    logic [IDXW-1:0]        ref_idx;

    always_comb begin
        req      = '0;
        own_op   = PINOOP;
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            req[i] = m_pi1_op_i[2*i +: 2] != PINOOP;
            if (gnt_r == IDXW'(i)) begin
                own_op   = m_pi1_op_i[2*i +: 2];
                own_addr = m_pi1_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
                own_data = m_pi1_data_i[ARCHBITSZ*i +: ARCHBITSZ];
                own_sel  = m_pi1_sel_i[SELW*i +: SELW];
            end
        end
    end

`ifdef PI1ARB_BURSTLIMIT_EN
    localparam int unsigned BCW = clog2(BURSTMAX + 1);

    logic [BCW-1:0] burstcnt_r;
    logic           other_req;
    logic           accept;

    always_comb begin
        other_req = 1'b0;
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            if (gnt_r != IDXW'(i)) begin
                other_req = other_req | req[i];
            end
        end
    end

    assign force_rel = gntvld_r && (burstcnt_r == BCW'(BURSTMAX)) && other_req;
    assign accept    = (s_pi1_op_o != PINOOP) && s_pi1_rdy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burstcnt_r <= '0;
        end else if (arb_en && found) begin
            burstcnt_r <= '0;
        end else if (accept && burstcnt_r != BCW'(BURSTMAX)) begin
            burstcnt_r <= burstcnt_r + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    assign rel     = gntvld_r && ((own_op == PINOOP) || force_rel);
    // A forced release blanks the owner for one cycle so nothing is accepted mid-rotation.
    assign fwd     = gntvld_r && !force_rel;
    assign arb_en  = !gntvld_r || rel;
    assign ref_idx = gntvld_r ? gnt_r : lastgnt_r;

    pi1_arb_rrpick #(
        .MASTERCOUNT(MASTERCOUNT)
    ) u_rrpick (
        .req    (req),
        .ref_idx(ref_idx),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        s_pi1_op_o   = PINOOP;
        s_pi1_addr_o = '0;
        s_pi1_data_o = '0;
        s_pi1_sel_o  = '0;
        m_pi1_rdy_o  = '0;
        if (fwd) begin
            s_pi1_op_o          = own_op;
            s_pi1_addr_o        = own_addr;
            s_pi1_data_o        = own_data;
            s_pi1_sel_o         = own_sel;
            m_pi1_rdy_o[gnt_r]  = s_pi1_rdy_i;
        end
    end

    assign m_pi1_data_o  = s_pi1_data_i;
    assign m_pi1_mapsz_o = s_pi1_mapsz_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gntvld_r  <= 1'b0;
            gnt_r     <= '0;
            lastgnt_r <= IDXW'(MASTERCOUNT - 1);
        end else if (arb_en) begin
            if (found) begin
                gntvld_r  <= 1'b1;
                gnt_r     <= winner;
                lastgnt_r <= winner;
            end else begin
                gntvld_r  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pi1_arb.sv
// Directed bench for pi1_arb with two masters, 32-bit data and BURSTMAX = 4.
module tb_pi1_arb;
    import pi1_pkg::*;

    localparam int unsigned MC  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned ADW = 30;
    localparam int unsigned SW  = 4;

    logic              clk;
    logic              rst;
    logic [2*MC-1:0]   m_op;
    logic [ADW*MC-1:0] m_addr;
    logic [AW*MC-1:0]  m_data;
    logic [SW*MC-1:0]  m_sel;
    logic [AW-1:0]     m_data_o;
    logic [MC-1:0]     m_rdy;
    logic [ADW-1:0]    m_mapsz;
    logic [1:0]        s_op;
    logic [ADW-1:0]    s_addr;
    logic [AW-1:0]     s_data;
    logic [SW-1:0]     s_sel;
    logic [AW-1:0]     s_data_i;
    logic              s_rdy_i;
    logic [ADW-1:0]    s_mapsz_i;

    int n_chk  = 0;
    int n_pass = 0;
    int rw_acc = 0;
    int own    = 0;

    pi1_arb #(
        .MASTERCOUNT(MC),
        .ARCHBITSZ  (AW),
        .BURSTMAX   (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m_pi1_op_i   (m_op),
        .m_pi1_addr_i (m_addr),
        .m_pi1_data_i (m_data),
        .m_pi1_sel_i  (m_sel),
        .m_pi1_data_o (m_data_o),
        .m_pi1_rdy_o  (m_rdy),
        .m_pi1_mapsz_o(m_mapsz),
        .s_pi1_op_o   (s_op),
        .s_pi1_addr_o (s_addr),
        .s_pi1_data_o (s_data),
        .s_pi1_sel_o  (s_sel),
        .s_pi1_data_i (s_data_i),
        .s_pi1_rdy_i  (s_rdy_i),
        .s_pi1_mapsz_i(s_mapsz_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count PIRWOP handshakes completed by master 1.
    always @(negedge clk) begin
        if (s_op == PIRWOP && s_rdy_i && m_rdy[1]) rw_acc <= rw_acc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int idx, input logic [1:0] op, input logic [ADW-1:0] addr,
                         input logic [AW-1:0] data);
        m_op[2*idx +: 2]     = op;
        m_addr[ADW*idx +: ADW] = addr;
        m_data[AW*idx +: AW]   = data;
    endtask

    initial begin
        rst       = 1'b1;
        m_op      = '0;
        m_addr    = '0;
        m_data    = '0;
        m_sel     = {4'hC, 4'h3};
        s_data_i  = '0;
        s_rdy_i   = 1'b0;
        s_mapsz_i = 30'h123;
        tick();
        tick();
        check("rst_sop", 64'(s_op), 64'd0);
        check("rst_rdy", 64'(m_rdy), 64'd0);
        check("rst_saddr", 64'(s_addr), 64'd0);
        check("mapsz", 64'(m_mapsz), 64'h123);
        rst = 1'b0;

        // Single read by master 0.
        set_m(0, PIRDOP, 30'd2, 32'hAA);
        s_rdy_i  = 1'b1;
        s_data_i = 32'd3;
        #1;
        check("t1_pre_sop", 64'(s_op), 64'(PINOOP));
        tick();
        check("t1_sop", 64'(s_op), 64'(PIRDOP));
        check("t1_saddr", 64'(s_addr), 64'd2);
        check("t1_ssel", 64'(s_sel), 64'h3);
        check("t1_rdy", 64'(m_rdy), 64'b01);
        set_m(0, PINOOP, 30'd0, 32'd0);
        #1;
        check("t1_rel_sop", 64'(s_op), 64'(PINOOP));
        tick();
        check("t1_mdata", 64'(m_data_o), 64'd3);
        check("t1_idle_rdy", 64'(m_rdy), 64'b00);

        // Both request from reset; master 0 first, handover costs one idle cycle.
        rst = 1'b1;
        set_m(0, PIRDOP, 30'd4, 32'h11);
        set_m(1, PIRDOP, 30'd5, 32'h22);
        tick();
        rst = 1'b0;
        tick();
        check("t2_own0_rdy", 64'(m_rdy), 64'b01);
        check("t2_own0_addr", 64'(s_addr), 64'd4);
        set_m(0, PINOOP, 30'd4, 32'h11);
        #1;
        check("t2_rel_sop", 64'(s_op), 64'(PINOOP));
        tick();
        check("t2_own1_rdy", 64'(m_rdy), 64'b10);
        check("t2_own1_addr", 64'(s_addr), 64'd5);
        check("t2_own1_data", 64'(s_data), 64'h22);
        check("t2_own1_sel", 64'(s_sel), 64'hC);
        set_m(0, PIRDOP, 30'd4, 32'h11);

        // Stalled PIRWOP keeps the grant.
        set_m(1, PIRWOP, 30'd1, 32'd0);
        s_rdy_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_rdy", 64'(m_rdy), 64'b00);
            check("t3_hold_sop", 64'(s_op), 64'(PIRWOP));
        end
        s_rdy_i = 1'b1;
        #1;
        check("t3_rdy", 64'(m_rdy), 64'b10);
        tick();
        set_m(1, PINOOP, 30'd1, 32'd0);
        #1;
        check("t3_rel_sop", 64'(s_op), 64'(PINOOP));
        check("t3_rw_acc", 64'(rw_acc), 64'd1);
        tick();
        check("t3_m0_regain", 64'(m_rdy), 64'b01);

        // Asynchronous reset while master 1 owns.
        set_m(0, PINOOP, 30'd4, 32'h11);
        set_m(1, PIRDOP, 30'd5, 32'h22);
        tick();
        check("t4_m1_owns", 64'(m_rdy), 64'b10);
        set_m(0, PIRDOP, 30'd4, 32'h11);
        #3;
        rst = 1'b1;
        #1;
        check("t4_rst_sop", 64'(s_op), 64'(PINOOP));
        check("t4_rst_rdy", 64'(m_rdy), 64'b00);
        #1;
        rst = 1'b0;
        tick();
        check("t4_m0_first", 64'(m_rdy), 64'b01);
        check("t4_m0_addr", 64'(s_addr), 64'd4);

        // Master 0 streams reads while master 1 waits.
`ifdef PI1ARB_BURSTLIMIT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_burst_rdy", 64'(m_rdy), 64'b01);
        end
        tick();
        check("t5_force_sop", 64'(s_op), 64'(PINOOP));
        check("t5_force_rdy", 64'(m_rdy), 64'b00);
        tick();
        check("t5_m1_rdy", 64'(m_rdy), 64'b10);
        check("t5_m1_addr", 64'(s_addr), 64'd5);
`else
        own = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (m_rdy == 2'b01 && s_addr == 30'd4) own++;
        end
        check("t6_own_cycles", 64'(own), 64'd100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
